// File: rtl/eth_cdc_tx_packer.sv
// Write-side packer for the eth CDC mailbox: splits NB*DW-bit words into DW-bit beats
// (LSB beat first) and closes each frame with a trailer beat holding its word count.
module eth_cdc_tx_packer #(
    parameter int DW = 8,
    parameter int NB = 4,
    parameter int FW = 16
) (
    input  logic                 aclri,
    input  logic                 wclki,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [NB*DW-1:0]     s_data,
    input  logic                 s_last,
    output logic                 wei,
    output logic [DW-1:0]        wdatai,
    input  logic                 fullo,
    output logic                 busy,
    output logic [FW-1:0]        tx_frames
);

    localparam int BW = (NB > 2) ? $clog2(NB) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(NB - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        TRAIL = 2'd2
    } state_t;

    state_t             state_q;
    logic [NB*DW-1:0]   sr_q;
    logic               last_q;
    logic [BW-1:0]      bcnt_q;
    logic [DW-1:0]      wcnt_q;
    logic [FW-1:0]      frames_q;
    logic               wei_q;
    logic [DW-1:0]      wdata_q;
    logic               ready_q;
    logic               busy_q;

    logic [NB*DW-1:0]   sr_shift_d;

    assign sr_shift_d = sr_q >> DW;

    // Outputs come straight from flops, so fullo never reaches wei/wdatai combinationally.
    assign s_ready   = ready_q;
    assign wei       = wei_q;
    assign wdatai    = wdata_q;
    assign busy      = busy_q;
    assign tx_frames = frames_q;

    always_ff @(posedge wclki or posedge aclri) begin
        if (aclri) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            last_q   <= 1'b0;
            bcnt_q   <= '0;
            wcnt_q   <= '0;
            frames_q <= '0;
            wei_q    <= 1'b0;
            wdata_q  <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_valid) begin
                        sr_q    <= s_data;
                        last_q  <= s_last;
                        bcnt_q  <= '0;
                        wcnt_q  <= wcnt_q + DW'(1);
                        state_q <= SEND;
                        ready_q <= 1'b0;
                        wei_q   <= 1'b1;
                        wdata_q <= s_data[DW-1:0];
                        busy_q  <= 1'b1;
                    end
                end
                SEND: begin
                    // While fullo is high everything holds; the mailbox masks the write.
                    if (!fullo) begin
                        sr_q   <= sr_shift_d;
                        bcnt_q <= bcnt_q + BW'(1);
                        if (bcnt_q == BEAT_LAST) begin
                            if (last_q) begin
                                state_q <= TRAIL;
                                wdata_q <= wcnt_q;
                            end else begin
                                state_q <= IDLE;
                                wei_q   <= 1'b0;
                                wdata_q <= '0;
                                ready_q <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            wdata_q <= sr_shift_d[DW-1:0];
                        end
                    end
                end
                TRAIL: begin
                    if (!fullo) begin
                        wcnt_q   <= '0;
                        frames_q <= frames_q + FW'(1);
                        state_q  <= IDLE;
                        wei_q    <= 1'b0;
                        wdata_q  <= '0;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    wei_q   <= 1'b0;
                    wdata_q <= '0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_cdc_tx_packer.sv
// Directed bench for eth_cdc_tx_packer: beat order, backpressure, mailbox-style fullo,
// count wrap, mid-frame reset and the hold protocol.
module tb_eth_cdc_tx_packer;

    localparam int DW = 8;
    localparam int NB = 4;
    localparam int FW = 16;

    logic              aclri;
    logic              wclki;
    logic              s_valid;
    logic              s_ready;
    logic [NB*DW-1:0]  s_data;
    logic              s_last;
    logic              wei;
    logic [DW-1:0]     wdatai;
    logic              fullo;
    logic              busy;
    logic [FW-1:0]     tx_frames;

    logic              fullo_force;
    logic              mb_mode;
    logic              mb_full;
    int unsigned       mb_cnt;

    logic [DW-1:0]     cap[$];
    logic [DW-1:0]     exp_q[$];

    int checks = 0;
    int errors = 0;

    assign fullo = mb_mode ? mb_full : fullo_force;

    eth_cdc_tx_packer #(.DW(DW), .NB(NB), .FW(FW)) dut (
        .aclri    (aclri),
        .wclki    (wclki),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .wei      (wei),
        .wdatai   (wdatai),
        .fullo    (fullo),
        .busy     (busy),
        .tx_frames(tx_frames)
    );

    initial wclki = 1'b0;
    always #5 wclki = ~wclki;

    // Mailbox stand-in: records every transferred beat; in mailbox mode it raises full
    // the cycle after each transfer and drops it after a variable drain delay.
    always @(posedge wclki) begin
        if (!aclri && wei && !fullo) begin
            cap.push_back(wdatai);
            if (mb_mode) begin
                mb_full <= 1'b1;
                mb_cnt  <= $urandom_range(2, 7);
            end
        end else if (mb_full) begin
            if (mb_cnt == 0) mb_full <= 1'b0;
            else             mb_cnt  <= mb_cnt - 1;
        end
    end

    task automatic step();
        @(posedge wclki);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [NB*DW-1:0] d, input logic l);
        bit got;
        got = 1'b0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            if (s_ready) begin
                got = 1'b1;
                break;
            end
            step();
        end
        if (!got) begin
            errors++;
            $error("FAIL ready_timeout observed=0 expected=1");
        end
        step();
        s_valid = 1'b0;
        $display("send word=%h last=%0d", d, l);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            step();
        end
        if (!done) begin
            errors++;
            $error("FAIL idle_timeout observed=busy expected=idle");
        end
    endtask

    task automatic chk_cap(input string tag);
        chk({tag, "_len"}, cap.size(), exp_q.size());
        if (cap.size() == exp_q.size()) begin
            for (int i = 0; i < exp_q.size(); i++)
                chk($sformatf("%s_beat%0d", tag, i), {24'd0, cap[i]}, {24'd0, exp_q[i]});
        end
    endtask

    initial begin
        aclri       = 1'b1;
        s_valid     = 1'b0;
        s_data      = '0;
        s_last      = 1'b0;
        fullo_force = 1'b0;
        mb_mode     = 1'b0;
        mb_full     = 1'b0;
        mb_cnt      = 0;

        // Reset state
        step();
        step();
        chk("rst_ready", s_ready, 1);
        chk("rst_wei", wei, 0);
        chk("rst_wdata", wdatai, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frames", tx_frames, 0);
        aclri = 1'b0;

        // Basic single-word frame, fullo tied low
        s_data = 32'h44332211; s_last = 1'b1; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        chk("b_wei", wei, 1);
        chk("b_busy", busy, 1);
        chk("b_ready", s_ready, 0);
        chk("b_beat0", wdatai, 8'h11);
        step(); chk("b_beat1", wdatai, 8'h22);
        step(); chk("b_beat2", wdatai, 8'h33);
        step(); chk("b_beat3", wdatai, 8'h44);
        step(); chk("b_trail", wdatai, 8'h01);
        chk("b_trail_wei", wei, 1);
        chk("b_frames_pre", tx_frames, 0);
        step();
        chk("b_ready_back", s_ready, 1);
        chk("b_wei_off", wei, 0);
        chk("b_frames", tx_frames, 1);
        $display("basic frame done tx_frames=%0d", tx_frames);

        // Backpressure after the first beat transfers
        cap.delete();
        send_word(32'h88776655, 1'b1);
        chk("bp_beat0", wdatai, 8'h55);
        step();
        chk("bp_beat1", wdatai, 8'h66);
        fullo_force = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("bp_hold_wei%0d", i), wei, 1);
            chk($sformatf("bp_hold_data%0d", i), wdatai, 8'h66);
        end
        fullo_force = 1'b0;
        wait_idle();
        exp_q = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h01};
        chk_cap("bp");
        chk("bp_frames", tx_frames, 2);

        // Mailbox-style fullo pattern, 3-word frame
        cap.delete();
        mb_mode = 1'b1;
        send_word(32'hA3A2A1A0, 1'b0);
        send_word(32'hB3B2B1B0, 1'b0);
        send_word(32'hC3C2C1C0, 1'b1);
        wait_idle();
        for (int i = 0; i < 10; i++) step();
        mb_mode = 1'b0;
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                  8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'h03};
        chk_cap("mb");
        chk("mb_frames", tx_frames, 3);

        // Hold protocol: s_valid/s_data wiggle while not ready
        cap.delete();
        send_word(32'h0D0C0B0A, 1'b1);
        for (int i = 0; i < 5; i++) begin
            s_valid = (i % 2 == 0);
            s_data  = $urandom;
            s_last  = 1'b0;
            step();
        end
        s_valid = 1'b0;
        step();
        step();
        exp_q = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h01};
        chk_cap("hold");
        chk("hold_busy", busy, 0);
        chk("hold_frames", tx_frames, 4);

        // Word-count wrap: 257 words, then a 2-word frame
        cap.delete();
        for (int i = 0; i < 257; i++)
            send_word(32'h0, (i == 256));
        wait_idle();
        chk("wrap_len", cap.size(), 257 * NB + 1);
        if (cap.size() > 0) chk("wrap_trail", {24'd0, cap[cap.size()-1]}, 32'h01);
        chk("wrap_frames", tx_frames, 5);
        cap.delete();
        send_word(32'h13121110, 1'b0);
        send_word(32'h17161514, 1'b1);
        wait_idle();
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h02};
        chk_cap("two");
        chk("two_frames", tx_frames, 6);

        // Reset after two beats of word 2
        send_word(32'h04030201, 1'b0);
        send_word(32'h08070605, 1'b0);
        step();
        step();
        chk("mid_beat2", wdatai, 8'h07);
        aclri   = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hDEADBEEF;
        s_last  = 1'b1;
        step();
        chk("mr_wei", wei, 0);
        chk("mr_wdata", wdatai, 0);
        chk("mr_ready", s_ready, 1);
        chk("mr_busy", busy, 0);
        chk("mr_frames", tx_frames, 0);
        step();
        aclri   = 1'b0;
        s_valid = 1'b0;
        step();
        chk("mr_nocap", wei, 0);
        cap.delete();
        send_word(32'h0F0E0D0C, 1'b1);
        wait_idle();
        exp_q = '{8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h01};
        chk_cap("mr");
        chk("mr_frames_after", tx_frames, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_cdc_tx_packer.md
# eth_cdc_tx_packer

Write-side frame packer for the single-entry clock-domain-crossing mailbox used in the eth path. It accepts wide words of NB×DW bits from a valid/ready source in the wclki domain. Each word is serialized into DW-bit beats, LSB beat first, and pushed through the mailbox write port (wei/wdatai/fullo). At the end of each frame it appends one trailer beat carrying the frame's word count.

## Interface
- DW, 8, beat width; matches the mailbox data width
- NB, 4, beats per input word (≥2)
- FW, 16, width of the tx_frames counter
- aclri  in  1  asynchronous reset, active-high
- wclki  in  1  write-domain clock; all logic is on its rising edge
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when s_valid && s_ready at rising edge
- s_data  in  NB*DW  input word; beat 0 = s_data[DW-1:0]
- s_last  in  1  word is last of frame
- wei  out  1  mailbox write request
- wdatai  out  DW  mailbox write data
- fullo  in  1  mailbox full; a beat transfers only on an edge with wei=1 && fullo=0
- busy  out  1  state ≠ IDLE
- tx_frames  out  FW  completed-frame counter, wraps mod 2^FW

## Operation
- States:
  - IDLE: s_ready=1, wei=0, wdatai=0.
  - SEND: s_ready=0, wei=1, wdatai=sr[DW-1:0].
  - TRAIL: s_ready=0, wei=1, wdatai=wcnt.
- Registers:
  - sr: NB*DW-bit shift register.
  - last_r: 1 bit.
  - bcnt: beat index, clog2(NB) bits.
  - wcnt: DW bits, words in the current frame.
  - tx_frames.
- IDLE, s_valid=1: capture s_data→sr and s_last→last_r, set bcnt=0, wcnt=wcnt+1 (wraps mod 2^DW), go to SEND.
- SEND, on transfer (wei && !fullo):
  - Shift sr right by DW (zero fill) and increment bcnt.
  - If bcnt==NB-1: go to TRAIL if last_r=1, else IDLE.
- SEND, fullo=1: hold. wei stays 1 and wdatai stays stable; the mailbox masks the write.
- TRAIL, on transfer: wcnt=0, tx_frames=tx_frames+1, go to IDLE.
- Trailer value is the number of words in the frame, including the last word, mod 2^DW.
- s_valid while s_ready=0 is ignored. The source must hold the word; no capture happens.
- wei and wdatai are decoded only from registered state. There is no combinational path from fullo to wei or wdatai.
- s_ready is decoded from state only; it does not depend on s_valid.
- Reset (aclri=1, any state, mid-frame included):
  - state=IDLE; sr, last_r, bcnt, wcnt and tx_frames = 0.
  - Outputs: wei=0, wdatai=0, busy=0, tx_frames=0, s_ready=1.
  - A partially sent frame is abandoned with no trailer. The next frame's count starts from 0.
  - Words presented while aclri=1 are not captured.

## Timing
- Capture edge k (IDLE, s_valid=1) → wei=1 with beat 0 on wdatai from cycle k+1.
- With fullo=0 continuously, one beat transfers per cycle:
  - NB data beats in cycles k+1..k+NB.
  - Trailer, if last, in cycle k+NB+1.
  - s_ready=1 again in the cycle after the final transfer.
- Minimum word period: NB+1 cycles for a non-last word, NB+2 for a last word.
- With the real mailbox, fullo rises the cycle after each transfer and falls only after the read side drains plus two wclki sync stages. The block must tolerate any fullo pattern.
- tx_frames updates on the trailer-transfer edge and is visible the next cycle.
- busy=1 from the cycle after capture through the cycle of the final transfer.

## Test plan
- NB=4, DW=8, fullo=0 tied. Word 0x44332211 with s_last=1 → wdatai beats 0x11, 0x22, 0x33, 0x44, 0x01 in 5 consecutive cycles. tx_frames 0→1. s_ready returns 1 in the 6th cycle.
- Backpressure: force fullo=1 for 10 cycles after beat 0x11 transfers → wei stays 1 and wdatai stays 0x22 for all 10 cycles. After release, the remaining beats follow with no loss or duplication.
- Real-mailbox loopback: 3-word frame 0xA3A2A1A0, 0xB3B2B1B0, 0xC3C2C1C0 (last on the third word), with an unrelated rclki at 0.37× wclki draining the mailbox → read side sees exactly 12 data beats in LSB-first order, then 0x03.
- Count wrap: 257-word frame at DW=8 → trailer 0x01 and tx_frames increments by 1. A back-to-back 2-word frame then gives trailer 0x02.
- Reset mid-frame: assert aclri after 2 beats of word 2 of a frame → all registers zero and wei=0, wdatai=0, s_ready=1 next cycle. A following 1-word last frame gives trailer 0x01 and tx_frames=1.
- Hold protocol: toggle s_valid and s_data every cycle during SEND/TRAIL → no capture occurs. The emitted beats match only the words accepted in IDLE.
